// File: rtl/l3_wb_buffer.sv
// L3 write-back buffer: queues evicted dirty lines, merges repeat evictions to
// not-yet-issued lines, forwards lookups, and drains each line as a single-beat AXI write.
module l3_wb_buffer #(
  parameter int          NUM_WB     = 8,
  parameter int          DATA_WIDTH = 512,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [3:0]  WB_QOS     = 4'h0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_req_valid,
  output logic                          wb_req_ready,
  input  logic [ADDR_WIDTH-1:0]         wb_req_addr,
  input  logic [DATA_WIDTH-1:0]         wb_req_data,
  input  logic [DATA_WIDTH/8-1:0]       wb_req_strb,
  input  logic [ADDR_WIDTH-1:0]         lkp_addr,
  output logic                          lkp_hit,
  output logic [DATA_WIDTH-1:0]         lkp_data,
  output logic                          maxi_awvalid,
  input  logic                          maxi_awready,
  output logic [ADDR_WIDTH-1:0]         maxi_awaddr,
  output logic [7:0]                    maxi_awlen,
  output logic [2:0]                    maxi_awsize,
  output logic [1:0]                    maxi_awburst,
  output logic [3:0]                    maxi_awqos,
  output logic                          maxi_wvalid,
  input  logic                          maxi_wready,
  output logic [DATA_WIDTH-1:0]         maxi_wdata,
  output logic [DATA_WIDTH/8-1:0]       maxi_wstrb,
  output logic                          maxi_wlast,
  input  logic                          maxi_bvalid,
  output logic                          maxi_bready,
  input  logic [1:0]                    maxi_bresp,
  output logic [$clog2(NUM_WB+1)-1:0]   wb_count,
  output logic                          wb_empty,
  output logic                          wb_err,
  input  logic                          err_clear
);

  localparam int PW = $clog2(NUM_WB);
  localparam int CW = $clog2(NUM_WB + 1);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(63);

  typedef enum logic [1:0] {FREE, QUEUED, ISSUING, WAIT_B} entry_state_e;

  entry_state_e          state_q [NUM_WB];
  entry_state_e          state_d [NUM_WB];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_WB];
  logic [ADDR_WIDTH-1:0] addr_d  [NUM_WB];
  logic [DATA_WIDTH-1:0] data_q  [NUM_WB];
  logic [DATA_WIDTH-1:0] data_d  [NUM_WB];
  logic [SW-1:0]         strb_q  [NUM_WB];
  logic [SW-1:0]         strb_d  [NUM_WB];

  logic [PW-1:0] alloc_q, alloc_d, issue_q, issue_d, retire_q, retire_d;
  logic [CW-1:0] count_q, count_d;
  logic          aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;

  logic [ADDR_WIDTH-1:0] req_line, lkp_line;
  logic                  issue_active, aw_hs, w_hs, b_hs, req_hs, alloc_en;
  logic                  merge_hit, any_wait_b;
  logic [PW-1:0]         merge_idx, lkp_idx;

  assign req_line     = wb_req_addr & ~LINE_MASK;
  assign lkp_line     = lkp_addr & ~LINE_MASK;
  assign issue_active = (state_q[issue_q] == QUEUED) || (state_q[issue_q] == ISSUING);

  assign maxi_awvalid = issue_active & ~aw_done_q;
  assign maxi_wvalid  = issue_active & ~w_done_q;
  assign maxi_awaddr  = addr_q[issue_q];
  assign maxi_awlen   = 8'd0;
  assign maxi_awsize  = 3'b110;
  assign maxi_awburst = 2'b01;
  assign maxi_awqos   = WB_QOS;
  assign maxi_wdata   = data_q[issue_q];
  assign maxi_wstrb   = strb_q[issue_q];
  assign maxi_wlast   = 1'b1;
  assign maxi_bready  = any_wait_b;

  assign aw_hs    = maxi_awvalid & maxi_awready;
  assign w_hs     = maxi_wvalid & maxi_wready;
  assign b_hs     = maxi_bvalid & maxi_bready;
  assign req_hs   = wb_req_valid & wb_req_ready;
  assign alloc_en = req_hs & ~merge_hit;

  assign wb_req_ready = (count_q < CW'(NUM_WB)) | merge_hit;
  assign wb_count     = count_q;
  assign wb_empty     = (count_q == '0);
  assign wb_err       = err_q;

  // The head entry stops being mergeable the moment either channel handshakes,
  // otherwise merged bytes could miss the W beat already on the wire.
  always_comb begin
    merge_hit  = 1'b0;
    merge_idx  = '0;
    any_wait_b = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (state_q[i] == WAIT_B) any_wait_b = 1'b1;
      if (state_q[i] == QUEUED && addr_q[i] == req_line &&
          !(PW'(i) == issue_q && (aw_hs || w_hs))) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  // Walk from oldest (retire pointer) to youngest so the last match wins.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_data = '0;
    lkp_idx  = '0;
    for (int j = 0; j < NUM_WB; j++) begin
      lkp_idx = retire_q + PW'(j);
      if (state_q[lkp_idx] != FREE && addr_q[lkp_idx] == lkp_line) begin
        lkp_hit  = 1'b1;
        lkp_data = data_q[lkp_idx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    alloc_d   = alloc_q;
    issue_d   = issue_q;
    retire_d  = retire_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;

    if (b_hs) begin
      state_d[retire_q] = FREE;
      retire_d          = retire_q + PW'(1);
    end

    if (aw_hs || w_hs) begin
      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
        state_d[issue_q] = WAIT_B;
        issue_d          = issue_q + PW'(1);
        aw_done_d        = 1'b0;
        w_done_d         = 1'b0;
      end else begin
        state_d[issue_q] = ISSUING;
        aw_done_d        = aw_done_q | aw_hs;
        w_done_d         = w_done_q | w_hs;
      end
    end

    if (req_hs && merge_hit) begin
      for (int b = 0; b < SW; b++) begin
        if (wb_req_strb[b]) data_d[merge_idx][b*8 +: 8] = wb_req_data[b*8 +: 8];
      end
      strb_d[merge_idx] = strb_q[merge_idx] | wb_req_strb;
    end else if (alloc_en) begin
      state_d[alloc_q] = QUEUED;
      addr_d[alloc_q]  = req_line;
      data_d[alloc_q]  = wb_req_data;
      strb_d[alloc_q]  = wb_req_strb;
      alloc_d          = alloc_q + PW'(1);
    end

    count_d = count_q + CW'(alloc_en) - CW'(b_hs);

    if (err_clear) begin
      err_d = 1'b0;
    end else if (b_hs && maxi_bresp != 2'b00) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WB; i++) state_q[i] <= FREE;
      alloc_q   <= '0;
      issue_q   <= '0;
      retire_q  <= '0;
      count_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alloc_q   <= alloc_d;
      issue_q   <= issue_d;
      retire_q  <= retire_d;
      count_q   <= count_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  // Payload storage is qualified by entry state, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

endmodule

// File: tb/tb_l3_wb_buffer.sv
// Self-checking bench for l3_wb_buffer: directed scenarios plus random traffic,
// all compared each cycle against a queue-based model of the buffer.
module tb_l3_wb_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_req_valid, wb_req_ready;
  logic [31:0]  wb_req_addr;
  logic [511:0] wb_req_data;
  logic [63:0]  wb_req_strb;
  logic [31:0]  lkp_addr;
  logic         lkp_hit;
  logic [511:0] lkp_data;
  logic         maxi_awvalid, maxi_awready;
  logic [31:0]  maxi_awaddr;
  logic [7:0]   maxi_awlen;
  logic [2:0]   maxi_awsize;
  logic [1:0]   maxi_awburst;
  logic [3:0]   maxi_awqos;
  logic         maxi_wvalid, maxi_wready;
  logic [511:0] maxi_wdata;
  logic [63:0]  maxi_wstrb;
  logic         maxi_wlast;
  logic         maxi_bvalid, maxi_bready;
  logic [1:0]   maxi_bresp;
  logic [3:0]   wb_count;
  logic         wb_empty, wb_err, err_clear;

  l3_wb_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_addr(wb_req_addr), .wb_req_data(wb_req_data), .wb_req_strb(wb_req_strb),
    .lkp_addr(lkp_addr), .lkp_hit(lkp_hit), .lkp_data(lkp_data),
    .maxi_awvalid(maxi_awvalid), .maxi_awready(maxi_awready), .maxi_awaddr(maxi_awaddr),
    .maxi_awlen(maxi_awlen), .maxi_awsize(maxi_awsize), .maxi_awburst(maxi_awburst),
    .maxi_awqos(maxi_awqos),
    .maxi_wvalid(maxi_wvalid), .maxi_wready(maxi_wready), .maxi_wdata(maxi_wdata),
    .maxi_wstrb(maxi_wstrb), .maxi_wlast(maxi_wlast),
    .maxi_bvalid(maxi_bvalid), .maxi_bready(maxi_bready), .maxi_bresp(maxi_bresp),
    .wb_count(wb_count), .wb_empty(wb_empty), .wb_err(wb_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
    logic [63:0]  strb;
  } line_t;

  // Model: lines not yet fully issued (head is on the bus) and lines awaiting B.
  line_t pend[$];
  line_t waitq[$];
  bit    head_aw, head_w, m_err;

  int checks = 0;
  int passes = 0;
  int aw_beats = 0;
  int w_beats = 0;

  always @(posedge clk) begin
    if (maxi_awvalid && maxi_awready) aw_beats <= aw_beats + 1;
    if (maxi_wvalid && maxi_wready) w_beats <= w_beats + 1;
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    pend.delete();
    waitq.delete();
    head_aw = 0;
    head_w  = 0;
    m_err   = 0;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one cycle of inputs, checks every output against the model, then advances the model.
  task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic [511:0] rd,
                               input logic [63:0] rs, input logic awr, input logic wr,
                               input logic bv, input logic [1:0] br, input logic [31:0] la,
                               input logic clr);
    int           cnt, mk;
    bit           has, exp_awv, exp_wv, aw_hs, w_hs, exp_rdy, exp_br, exp_hit;
    logic [511:0] exp_ld;
    logic [31:0]  rline, lline;
    line_t        t;

    wb_req_valid = rv;  wb_req_addr = ra;  wb_req_data = rd;  wb_req_strb = rs;
    maxi_awready = awr; maxi_wready = wr;  maxi_bvalid = bv;  maxi_bresp = br;
    lkp_addr = la;      err_clear = clr;
    #1;
    rline   = ra & ~32'h3F;
    lline   = la & ~32'h3F;
    cnt     = pend.size() + waitq.size();
    has     = pend.size() > 0;
    exp_awv = has && !head_aw;
    exp_wv  = has && !head_w;
    aw_hs   = exp_awv && awr;
    w_hs    = exp_wv && wr;
    mk      = -1;
    foreach (pend[k]) begin
      if (pend[k].addr == rline && (k > 0 || (!head_aw && !head_w && !aw_hs && !w_hs))) mk = k;
    end
    exp_rdy = (cnt < 8) || (mk >= 0);
    exp_br  = waitq.size() > 0;
    exp_hit = 0;
    exp_ld  = '0;
    foreach (waitq[k]) if (waitq[k].addr == lline) begin exp_hit = 1; exp_ld = waitq[k].data; end
    foreach (pend[k])  if (pend[k].addr == lline)  begin exp_hit = 1; exp_ld = pend[k].data; end

    checkOutput("req_ready", wb_req_ready, exp_rdy);
    checkOutput("awvalid", maxi_awvalid, exp_awv);
    checkOutput("wvalid", maxi_wvalid, exp_wv);
    checkOutput("bready", maxi_bready, exp_br);
    checkOutput("count", wb_count, cnt);
    checkOutput("empty", wb_empty, cnt == 0);
    checkOutput("err", wb_err, m_err);
    checkOutput("lkp_hit", lkp_hit, exp_hit);
    checkOutput("lkp_data", lkp_data, exp_ld);
    if (exp_awv) begin
      checkOutput("awaddr", maxi_awaddr, pend[0].addr);
      checkOutput("aw_attr", {maxi_awlen, maxi_awsize, maxi_awburst, maxi_awqos},
                  {8'd0, 3'b110, 2'b01, 4'h0});
    end
    if (exp_wv) begin
      checkOutput("wdata", maxi_wdata, pend[0].data);
      checkOutput("wstrb", maxi_wstrb, pend[0].strb);
      checkOutput("wlast", maxi_wlast, 1'b1);
    end

    @(posedge clk);
    if (exp_br && bv) begin
      void'(waitq.pop_front());
      if (br != 2'b00) m_err = 1;
    end
    if (clr) m_err = 0;
    if (rv && exp_rdy) begin
      if (mk >= 0) begin
        t = pend[mk];
        for (int b = 0; b < 64; b++) if (rs[b]) t.data[b*8 +: 8] = rd[b*8 +: 8];
        t.strb   = t.strb | rs;
        pend[mk] = t;
      end else begin
        t.addr = rline; t.data = rd; t.strb = rs;
        pend.push_back(t);
      end
    end
    if (aw_hs) head_aw = 1;
    if (w_hs)  head_w  = 1;
    if (head_aw && head_w) begin
      waitq.push_back(pend.pop_front());
      head_aw = 0;
      head_w  = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [511:0] pat_a5, dx, dy, dd;
    int beats0;

    pat_a5 = {64{8'hA5}};
    dx = rand_line();
    dy = rand_line();
    dd = rand_line();
    rst_n = 1'b0;
    wb_req_valid = 0; wb_req_addr = '0; wb_req_data = '0; wb_req_strb = '0;
    maxi_awready = 0; maxi_wready = 0; maxi_bvalid = 0; maxi_bresp = 0;
    lkp_addr = '0; err_clear = 0;
    modelReset();
    #3;
    checkOutput("rst_count", wb_count, 4'd0);
    checkOutput("rst_empty", wb_empty, 1'b1);
    checkOutput("rst_ready", wb_req_ready, 1'b1);
    checkOutput("rst_valids", {maxi_awvalid, maxi_wvalid, maxi_bready, lkp_hit, wb_err}, 5'b0);
    checkOutput("rst_lkp_data", lkp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single eviction");
    applyStimulus(1, 32'h8000_0040, pat_a5, '1, 1, 1, 0, 0, 32'h0, 0);
    checkOutput("single_awvalid", maxi_awvalid, 1'b1);
    checkOutput("single_awaddr", maxi_awaddr, 32'h8000_0040);
    checkOutput("single_wdata", maxi_wdata, pat_a5);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 0, 0, 32'h8000_0040, 0);
    checkOutput("single_bready", maxi_bready, 1'b1);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h0, 0);
    checkOutput("single_empty", wb_empty, 1'b1);

    $display("[TB] fill, stall and merge when full");
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 32'h1000 + i * 64, rand_line(), '1, 0, 0, 0, 0, 32'h1000, 0);
    checkOutput("fill_count", wb_count, 4'd8);
    applyStimulus(1, 32'h2000, rand_line(), '1, 0, 0, 1, 0, 32'h0, 0);
    checkOutput("full_stall_ready", wb_req_ready, 1'b0);
    checkOutput("full_stall_count", wb_count, 4'd8);
    applyStimulus(1, 32'h1000 + 7 * 64 + 32'h15, rand_line(), 64'h00F0_0F00_0000_FFFF,
                  0, 0, 0, 0, 32'h11C0, 0);
    checkOutput("full_merge_count", wb_count, 4'd8);
    for (int i = 0; i < 20; i++) applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h11C0, 0);
    checkOutput("fill_drained", wb_empty, 1'b1);

    $display("[TB] merge of partial strobes");
    beats0 = aw_beats;
    applyStimulus(1, 32'h100, dx, 64'h00FF, 0, 0, 0, 0, 32'h100, 0);
    applyStimulus(1, 32'h100, dy, 64'hFF00, 0, 0, 0, 0, 32'h100, 0);
    checkOutput("merge_count", wb_count, 4'd1);
    checkOutput("merge_wstrb", maxi_wstrb, 64'hFFFF);
    checkOutput("merge_wdata_lo", maxi_wdata[127:0], {dy[127:64], dx[63:0]});
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h100, 0);
    checkOutput("merge_one_aw", aw_beats - beats0, 1);

    $display("[TB] lookup forwarding");
    applyStimulus(1, 32'h200, dd, '1, 1, 1, 0, 0, 32'h23F, 0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 0, 0, 32'h23F, 0);
    checkOutput("lkp_wait_hit", lkp_hit, 1'b1);
    checkOutput("lkp_wait_data", lkp_data, dd);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h23F, 0);
    checkOutput("lkp_after_b", lkp_hit, 1'b0);

    $display("[TB] split AW/W handshakes");
    beats0 = w_beats;
    applyStimulus(1, 32'h300, rand_line(), '1, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, '0, '0, 0, 1, 0, 0, 32'h0, 0);
    checkOutput("split_wvalid_drop", maxi_wvalid, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, '0, '0, 0, 1, 0, 0, 32'h300, 0);
    checkOutput("split_no_waitb", maxi_bready, 1'b0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 0, 0, 32'h300, 0);
    checkOutput("split_waitb", maxi_bready, 1'b1);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h0, 0);
    checkOutput("split_one_w", w_beats - beats0, 1);

    $display("[TB] error response and clear");
    applyStimulus(1, 32'h500, rand_line(), '1, 1, 1, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 2'b10, 32'h0, 0);
    checkOutput("err_set", wb_err, 1'b1);
    checkOutput("err_freed", wb_empty, 1'b1);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 0, 0, 32'h0, 1);
    checkOutput("err_cleared", wb_err, 1'b0);
    applyStimulus(1, 32'h540, rand_line(), '1, 1, 1, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 2'b11, 32'h0, 1);
    checkOutput("err_clear_priority", wb_err, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 1),
                    32'h400 + $urandom_range(0, 5) * 64 + $urandom_range(0, 63),
                    rand_line(), {$urandom, $urandom},
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 1),
                    ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00,
                    32'h400 + $urandom_range(0, 6) * 64 + $urandom_range(0, 63),
                    $urandom_range(0, 19) == 0);
    end

    $display("[TB] reset mid-transfer");
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'h600 + i * 64, rand_line(), '1, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("pre_reset_count", wb_count, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_count", wb_count, 4'd0);
    checkOutput("midrst_awvalid", maxi_awvalid, 1'b0);
    checkOutput("midrst_wvalid", maxi_wvalid, 1'b0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 32'h700, rand_line(), '1, 1, 1, 0, 0, 32'h700, 0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 0, 0, 32'h700, 0);
    applyStimulus(0, 32'h0, '0, '0, 1, 1, 1, 0, 32'h700, 0);
    checkOutput("post_reset_empty", wb_empty, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/l3_wb_buffer.md
Name: l3_wb_buffer

Overview:
- Write-back buffer directly downstream of the L3 cache controller.
- Accepts evicted dirty 64B lines, queues them, and drains each one to the NoC/DDR master AXI write channels as a single-beat 512-bit burst.
- Provides a same-cycle address lookup so the controller can forward data for a line that has been evicted but not yet written to memory.
- Merges repeat evictions to a queued, not-yet-issued line.

Parameters:
- NUM_WB, 8: buffer entries (power of 2, ≥2).
- DATA_WIDTH, 512: line width in bits.
- ADDR_WIDTH, 32: address width.
- WB_QOS, 4'h0: value driven on maxi_awqos.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_req_valid  in  1  eviction request valid.
- wb_req_ready  out  1  buffer can accept or merge.
- wb_req_addr  in  ADDR_WIDTH  line address; bits [5:0] are ignored and forced to 0.
- wb_req_data  in  DATA_WIDTH  line data.
- wb_req_strb  in  DATA_WIDTH/8  byte-valid mask.
- lkp_addr  in  ADDR_WIDTH  lookup address (line granularity).
- lkp_hit  out  1  lookup matches a valid entry (combinational).
- lkp_data  out  DATA_WIDTH  data of the youngest matching entry; 0 on miss.
- maxi_awvalid/awready/awaddr/awlen/awsize/awburst/awqos: AXI AW channel, 1/1/ADDR_WIDTH/8/3/2/4 bits.
- maxi_wvalid/wready/wdata/wstrb/wlast: AXI W channel, 1/1/DATA_WIDTH/DATA_WIDTH/8/1 bits.
- maxi_bvalid  in  1;  maxi_bready  out  1;  maxi_bresp  in  2.
- wb_count  out  $clog2(NUM_WB+1)  occupied entries.
- wb_empty  out  1  wb_count==0.
- wb_err  out  1  sticky: a B response other than OKAY was received.
- err_clear  in  1  clears wb_err.

Behaviour:
- Per-entry state: FREE → QUEUED → ISSUING → WAIT_B → FREE.
- Circular buffer with three pointers: alloc, issue, retire. Entries are allocated, issued and retired strictly in order.

Request acceptance:
- wb_req_ready = (wb_count < NUM_WB) OR a merge target exists.
- A merge target is a QUEUED entry (neither AW nor W accepted yet) with an equal line address.
- Handshake = valid & ready.
- On merge: for each byte with strb=1, overwrite data and set strb; no new entry; wb_count unchanged.
- Otherwise: allocate at the alloc pointer, state = QUEUED, wb_count+1.

Issue:
- When the issue-pointer entry is QUEUED or ISSUING, drive both channels:
  - awvalid with awaddr = entry address, awlen=0, awsize=3'b110, awburst=2'b01, awqos=WB_QOS.
  - wvalid with wdata, wstrb = entry strb, wlast=1.
- AW and W handshake independently, in the same or different cycles. Each valid drops after its own handshake.
- The entry moves to WAIT_B and the issue pointer advances once both channels have handshaken.
- While either handshake is pending, state = ISSUING and the entry is not mergeable.
- Issue starts the cycle after allocation (registered). Minimum latency: wb_req handshake at cycle N → awvalid/wvalid at N+1.

Retire:
- maxi_bready = 1 while any entry is in WAIT_B, else 0.
- B handshake frees the retire-pointer entry (wb_count−1).
- bresp != 2'b00 sets wb_err. err_clear has priority over a same-cycle set.

Lookup:
- Searches all non-FREE entries, including WAIT_B.
- The youngest match wins.
- Lookup sees registered contents only: a merge or allocation in the same cycle is not visible until the next cycle.
- An entry retired this cycle is still visible this cycle.

Simultaneous events:
- Allocate and retire in the same cycle: wb_count is unchanged.
- When full, wb_req_ready stays 0 even if a B arrives that cycle, except for a merge target.

Pointer and counter widths:
- Pointers are $clog2(NUM_WB) bits and wrap naturally.

Reset (asynchronous):
- All entries FREE, all pointers 0, wb_count=0, wb_empty=1, wb_err=0.
- awvalid, wvalid, bready, lkp_hit = 0; lkp_data=0; wb_req_ready=1.
- Reset mid-transfer abandons all in-flight entries without completing their handshakes.

Test Plan:
- Single eviction: addr 0x8000_0040, data pattern A5, full strb; awready=wready=1 → AW/W at cycle+1 with awaddr 0x8000_0040, awlen 0, wlast 1; entry retires on B; wb_empty=1.
- Fill: awready=0, 8 evictions → wb_count=8, wb_req_ready=0. A 9th request to a new address stalls. A 9th request matching the 8th (QUEUED) address merges and is accepted.
- Merge: two requests to 0x100 with strb 0x..00FF then 0x..FF00, with AW held off → exactly one AW; wstrb = 0x..FFFF; data holds the low bytes of the first request and the next bytes of the second.
- Lookup forwarding: evict 0x200 with data D, hold bvalid=0 → lkp_addr=0x23F gives lkp_hit=1, lkp_data=D. After B completes, lkp_hit=0.
- Split handshakes: wready=1 at cycle 1, awready at cycle 4 → wvalid drops after cycle 1; the entry enters WAIT_B only after cycle 4; only one W beat is issued.
- Error and reset: bresp=2'b10 → wb_err=1 and the entry is still freed; err_clear → 0. Asserting rst_n=0 while 3 entries are occupied → wb_count=0 and awvalid=0 immediately.
